imem_loader: RTL

Boot-time program loader that writes the instruction memory the pipelined RV32I core fetches from. It accepts a byte stream over a valid/ready handshake: a 2-byte word count, the program words, then a checksum byte. It assembles the bytes into 32-bit little-endian words and issues one write per word. The core is held in reset until the load completes successfully.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/loader_word_packer.sv | 44 ++++
 rtl/imem_loader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/loader_word_packer.sv
// Assembles little-endian bytes into a 32-bit word; byte 0 ends up in bits [7:0].
module loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic        word_full,
  output logic [31:0] word_nxt
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    // New bytes enter at the top lane and shift down, so after four bytes
    // the first one sits in the lowest lane.
    word_nxt   = {byte_in, word_q[31:8]};
    word_full  = byte_vld && (byte_idx_q == 2'(BYTES_PER_WORD - 1));
    if (clear) begin
      byte_idx_d = 2'd0;
    end else if (byte_vld) begin
      word_d     = word_nxt;
      byte_idx_d = byte_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q <= 2'd0;
    end else begin
      byte_idx_q <= byte_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header, little-endian program words, XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [16:0] word_idx_q, word_idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        accept;
  logic        pk_clear;
  logic        pk_full;
  logic [31:0] pk_word_nxt;

  assign rx_ready  = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                     (state_q == ST_DATA) || (state_q == ST_CHK);
  assign accept    = rx_valid && rx_ready;
  assign mem_we    = (state_q == ST_WRITE);
  assign busy      = rx_ready || (state_q == ST_WRITE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERR);
  assign core_hold = (state_q != ST_DONE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  loader_word_packer u_packer (
    .clk      (clk),
    .rst_n    (rst),
    .clear    (pk_clear),
    .byte_vld (accept && (state_q == ST_DATA)),
    .byte_in  (rx_data),
    .word_full(pk_full),
    .word_nxt (pk_word_nxt)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    csum_d      = csum_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pk_clear    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_d = ST_LEN0;
      end
      ST_LEN0: begin
        if (accept) begin
          count_d = {8'h00, rx_data};
          state_d = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (accept) begin
          count_d    = {rx_data, count_q[7:0]};
          word_idx_d = 17'd0;
          csum_d     = 8'h00;
          pk_clear   = 1'b1;
          if (count_d == 16'd0)                 state_d = ST_CHK;
          else if ({1'b0, count_d} > CAPACITY)  state_d = ST_ERR;
          else                                  state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
          if (pk_full) begin
            // Latch the write beat now so address and data stay stable after it.
            mem_addr_d  = {{(30-ADDR_W){1'b0}}, word_idx_q[ADDR_W-1:0], 2'b00};
            mem_wdata_d = pk_word_nxt;
            state_d     = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        word_idx_d = word_idx_q + 17'd1;
        pk_clear   = 1'b1;
        state_d    = (word_idx_d == {1'b0, count_q}) ? ST_CHK : ST_DATA;
      end
      ST_CHK: begin
        if (accept) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      count_q     <= 16'd0;
      word_idx_q  <= 17'd0;
      csum_q      <= 8'h00;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      csum_q      <= csum_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule
